uart_rx_frame_ctrl: RTL and testbench

Frame controller that sits directly behind the UART receiver and drains its byte handshake (Data/Ready/Ack). It parses a sync/address/length/payload frame and turns each accepted frame into a burst of single-cycle register writes on the local register bus. It is the only consumer of the receiver and the only UART-side master of the register bus.

---
 rtl/uart_rx_frame_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART receiver: turns SYNC/ADDR/LEN/payload frames into register writes.
// Define UART_FRAME_CHECKSUM_EN for the buffered build with a trailing CHK byte and commit phase.
module uart_rx_frame_ctrl #(
  parameter int unsigned          MAX_LEN   = 16,
  parameter int unsigned          TIMEOUT_N = 16,
  parameter logic [TIMEOUT_N-1:0] TIMEOUT   = 16'd50000,
  parameter logic [7:0]           SYNC      = 8'hA5
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic [7:0] RxData,
  input  logic       RxReady,
  output logic       RxAck,
  output logic [7:0] WrAddress,
  output logic [7:0] WrData,
  output logic       WrEnable,
  output logic       FrameOk,
  output logic       FrameError,
  output logic       Busy
);

  typedef enum logic [2:0] {
    S_HUNT, S_ADDR, S_LEN, S_PAYLOAD, S_CHECK, S_COMMIT
  } state_t;

  localparam logic [7:0]           MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TIMEOUT_N-1:0] TMO_ONE   = TIMEOUT_N'(1);
  localparam logic [TIMEOUT_N-1:0] TMO_LAST  = TIMEOUT - TMO_ONE;

  state_t               state_q, state_d;
  logic                 ack_q, ack_d;
  logic [7:0]           addr_q, addr_d;
  logic [7:0]           len_q, len_d;
  logic [7:0]           idx_q, idx_d;
  logic [TIMEOUT_N-1:0] tmo_q, tmo_d;
  logic                 wr_en_q, wr_en_d;
  logic [7:0]           wr_addr_q, wr_addr_d;
  logic [7:0]           wr_data_q, wr_data_d;
  logic                 ok_q, ok_d;
  logic                 err_q, err_d;
  logic                 cap;
  logic                 counting;

`ifdef UART_FRAME_CHECKSUM_EN
  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  logic [7:0] sum_q, sum_d;
  logic [7:0] chk_sum;
  logic [7:0] buf_q [MAX_LEN];

  // Payload storage needs no reset: it is always rewritten before being committed.
  always_ff @(posedge Clk) begin
    if (state_q == S_PAYLOAD && cap) buf_q[idx_q[IDX_W-1:0]] <= RxData;
  end
`endif

  always_comb begin
    state_d   = state_q;
    ack_d     = ack_q;
    addr_d    = addr_q;
    len_d     = len_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    cap       = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
    sum_d     = sum_q;
    chk_sum   = sum_q + RxData;
`endif

    // Four-phase handshake; capture is suppressed while committing buffered writes.
    if (ack_q) begin
      if (!RxReady) ack_d = 1'b0;
    end else if (RxReady && state_q != S_COMMIT) begin
      cap   = 1'b1;
      ack_d = 1'b1;
    end

    counting = (state_q == S_ADDR) || (state_q == S_LEN) ||
               (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    if (cap || !counting) tmo_d = '0;
    else                  tmo_d = tmo_q + TMO_ONE;

    case (state_q)
      S_HUNT: begin
        if (cap && RxData == SYNC) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (cap) begin
          addr_d  = RxData;
          state_d = S_LEN;
`ifdef UART_FRAME_CHECKSUM_EN
          sum_d   = RxData;
`endif
        end
      end
      S_LEN: begin
        if (cap) begin
          len_d = RxData;
          idx_d = 8'd0;
`ifdef UART_FRAME_CHECKSUM_EN
          sum_d = chk_sum;
`endif
          if (RxData > MAX_LEN_B) begin
            err_d   = 1'b1;
            state_d = S_HUNT;
          end else if (RxData == 8'd0) begin
`ifdef UART_FRAME_CHECKSUM_EN
            state_d = S_CHECK;
`else
            ok_d    = 1'b1;
            state_d = S_HUNT;
`endif
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (cap) begin
          idx_d = idx_q + 8'd1;
`ifdef UART_FRAME_CHECKSUM_EN
          sum_d = chk_sum;
          if (idx_q + 8'd1 == len_q) state_d = S_CHECK;
`else
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q + idx_q;
          wr_data_d = RxData;
          // A one-cycle Commit visit places FrameOk after the final write strobe.
          if (idx_q + 8'd1 == len_q) state_d = S_COMMIT;
`endif
        end
      end
`ifdef UART_FRAME_CHECKSUM_EN
      S_CHECK: begin
        if (cap) begin
          if (chk_sum != 8'h00) begin
            err_d   = 1'b1;
            state_d = S_HUNT;
          end else if (len_q == 8'd0) begin
            ok_d    = 1'b1;
            state_d = S_HUNT;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = buf_q[0];
            idx_d     = 8'd1;
            state_d   = S_COMMIT;
          end
        end
      end
      S_COMMIT: begin
        if (idx_q == len_q) begin
          ok_d    = 1'b1;
          state_d = S_HUNT;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q + idx_q;
          wr_data_d = buf_q[idx_q[IDX_W-1:0]];
          idx_d     = idx_q + 8'd1;
        end
      end
`else
      S_COMMIT: begin
        ok_d    = 1'b1;
        state_d = S_HUNT;
      end
`endif
      default: state_d = S_HUNT;
    endcase

    if (counting && !cap && tmo_q == TMO_LAST) begin
      err_d   = 1'b1;
      state_d = S_HUNT;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= S_HUNT;
      ack_q     <= 1'b0;
      addr_q    <= 8'd0;
      len_q     <= 8'd0;
      idx_q     <= 8'd0;
      tmo_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'd0;
      wr_data_q <= 8'd0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      sum_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
`ifdef UART_FRAME_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign RxAck      = ack_q;
  assign WrAddress  = wr_addr_q;
  assign WrData     = wr_data_q;
  assign WrEnable   = wr_en_q;
  assign FrameOk    = ok_q;
  assign FrameError = err_q;
  assign Busy       = (state_q != S_HUNT);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: vector table of frames with a write scoreboard, plus
// hand sequences for handshake timing, inter-byte timeout and reset during a write burst.
module tb_uart_rx_frame_ctrl;

  localparam int unsigned MAX_LEN = 16;
  localparam logic [15:0] TMO     = 16'd40;
  localparam logic [7:0]  SYNC    = 8'hA5;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       nReset = 1'b0;
  logic [7:0] RxData = 8'd0;
  logic       RxReady = 1'b0;
  logic       RxAck;
  logic [7:0] WrAddress;
  logic [7:0] WrData;
  logic       WrEnable;
  logic       FrameOk;
  logic       FrameError;
  logic       Busy;

  uart_rx_frame_ctrl #(
    .MAX_LEN(MAX_LEN), .TIMEOUT_N(16), .TIMEOUT(TMO), .SYNC(SYNC)
  ) dut (
    .Clk(Clk), .nReset(nReset), .RxData(RxData), .RxReady(RxReady), .RxAck(RxAck),
    .WrAddress(WrAddress), .WrData(WrData), .WrEnable(WrEnable),
    .FrameOk(FrameOk), .FrameError(FrameError), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] len;
    logic [7:0] seed;   // payload byte i = seed + i*step
    logic [7:0] step;
    logic [7:0] chk_delta;
    logic       junk;   // non-SYNC byte sent before the frame
    logic       exp_good;
  } vec_t;

  wr_t  wq[$];
  int   total = 0;
  int   bad = 0;
  int   ok_cnt = 0;
  int   err_cnt = 0;
  bit   sb_en = 1'b1;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    wr_t e;
    if (FrameOk) ok_cnt++;
    if (FrameError) err_cnt++;
    if (FrameOk || FrameError) check("ok_err_excl", int'(FrameOk & FrameError), 0);
    if (WrEnable && sb_en) begin
      check("wr_expected", int'(wq.size() != 0), 1);
      if (wq.size() != 0) begin
        e = wq.pop_front();
        check("wr_addr", int'(WrAddress), int'(e.a));
        check("wr_data", int'(WrData), int'(e.d));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(posedge Clk); #1;
    RxData  = b;
    RxReady = 1'b1;
    n = 0;
    while (!RxAck && n < 20) begin @(posedge Clk); #1; n++; end
    check("ack_rise", int'(RxAck), 1);
    RxReady = 1'b0;
    n = 0;
    while (RxAck && n < 20) begin @(posedge Clk); #1; n++; end
    check("ack_fall", int'(RxAck), 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [7:0] s, p;
    int ok0, er0, n;
    ok0 = ok_cnt;
    er0 = err_cnt;
    if (v.junk) send_byte(8'h00);
    send_byte(SYNC);
    send_byte(v.addr);
    send_byte(v.len);
    s = v.addr + v.len;
    if (v.len <= 8'(MAX_LEN)) begin
      for (int i = 0; i < int'(v.len); i++) begin
        p = v.seed + 8'(i) * v.step;
        s = s + p;
        if (v.exp_good) wq.push_back('{a: v.addr + 8'(i), d: p});
        send_byte(p);
      end
      if (CHK_EN) send_byte(8'h00 - s + v.chk_delta);
    end
    n = 0;
    while (ok_cnt == ok0 && err_cnt == er0 && n < 60) begin @(negedge Clk); n++; end
    repeat (3) @(negedge Clk);
    check($sformatf("v%0d_ok", idx), ok_cnt - ok0, v.exp_good ? 1 : 0);
    check($sformatf("v%0d_err", idx), err_cnt - er0, v.exp_good ? 0 : 1);
    check($sformatf("v%0d_writes_done", idx), wq.size(), 0);
    check($sformatf("v%0d_idle", idx), int'(Busy), 0);
    wq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    logic [7:0] s, len_m;
    int n, ok0;

    vecs[0] = '{addr: 8'h10, len: 8'd2,  seed: 8'h11, step: 8'h11, chk_delta: 8'd0, junk: 1'b0, exp_good: 1'b1};
    vecs[1] = '{addr: 8'hFF, len: 8'd2,  seed: 8'h01, step: 8'h01, chk_delta: 8'd0, junk: 1'b0, exp_good: 1'b1};
    vecs[2] = '{addr: 8'h33, len: 8'd0,  seed: 8'h00, step: 8'h00, chk_delta: 8'd0, junk: 1'b1, exp_good: 1'b1};
    vecs[3] = '{addr: 8'h40, len: 8'd16, seed: 8'h30, step: 8'h03, chk_delta: 8'd0, junk: 1'b0, exp_good: 1'b1};
    vecs[4] = '{addr: 8'h50, len: 8'd17, seed: 8'h00, step: 8'h00, chk_delta: 8'd0, junk: 1'b0, exp_good: 1'b0};
    vecs[5] = '{addr: 8'hA5, len: 8'd1,  seed: 8'hA5, step: 8'h00, chk_delta: 8'd0, junk: 1'b0, exp_good: 1'b1};
    vecs[6] = '{addr: 8'h60, len: 8'd3,  seed: 8'h07, step: 8'h02, chk_delta: 8'd1, junk: 1'b0, exp_good: !CHK_EN};
    vecs[7] = '{addr: 8'hFE, len: 8'd3,  seed: 8'hAA, step: 8'h11, chk_delta: 8'd0, junk: 1'b0, exp_good: 1'b1};

    // Reset state
    #22;
    check("rst_ack", int'(RxAck), 0);
    check("rst_wren", int'(WrEnable), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_waddr", int'(WrAddress), 0);
    check("rst_wdata", int'(WrData), 0);
    @(posedge Clk); #1 nReset = 1'b1;
    repeat (2) @(negedge Clk);
    check("post_rst_busy", int'(Busy), 0);
    check("post_rst_err", int'(FrameError), 0);

    // Ack rises the cycle after RxReady is seen, holds, and falls the cycle after it drops
    @(posedge Clk); #1;
    RxData = SYNC; RxReady = 1'b1;
    @(posedge Clk); #1;
    check("ack_rise_timing", int'(RxAck), 1);
    repeat (3) begin @(posedge Clk); #1; end
    check("ack_held", int'(RxAck), 1);
    check("busy_after_sync", int'(Busy), 1);
    RxReady = 1'b0;
    @(posedge Clk); #1;
    check("ack_fall_timing", int'(RxAck), 0);

    // Stall after ADDR until the inter-byte timeout fires
    send_byte(8'h20);
    n = 0;
    while (!FrameError && n < 200) begin @(negedge Clk); n++; end
    check("tmo_err", int'(FrameError), 1);
    check("tmo_window", int'(n >= int'(TMO) - 5 && n <= int'(TMO) + 5), 1);
    repeat (2) @(negedge Clk);
    check("tmo_hunt", int'(Busy), 0);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset while a write burst is in progress
    sb_en = 1'b0;
    ok0 = ok_cnt;
    len_m = CHK_EN ? 8'd16 : 8'd4;
    send_byte(SYNC);
    send_byte(8'h80);
    send_byte(len_m);
    s = 8'h80 + len_m;
    if (CHK_EN) begin
      for (int i = 0; i < 16; i++) begin send_byte(8'(i)); s = s + 8'(i); end
    end
    @(posedge Clk); #1;
    RxData = CHK_EN ? 8'(8'h00 - s) : 8'h00;
    RxReady = 1'b1;
    n = 0;
    while (!(WrEnable && (!CHK_EN || WrAddress == 8'h84)) && n < 40) begin @(negedge Clk); n++; end
    check("mid_wr_seen", int'(WrEnable), 1);
    #2 nReset = 1'b0;
    #1;
    check("mid_rst_ack", int'(RxAck), 0);
    check("mid_rst_wren", int'(WrEnable), 0);
    check("mid_rst_ok", int'(FrameOk), 0);
    check("mid_rst_err", int'(FrameError), 0);
    check("mid_rst_busy", int'(Busy), 0);
    check("mid_rst_waddr", int'(WrAddress), 0);
    check("mid_rst_wdata", int'(WrData), 0);
    RxReady = 1'b0;
    repeat (2) @(posedge Clk);
    #1 nReset = 1'b1;
    sb_en = 1'b1;
    repeat (5) @(negedge Clk);
    check("mid_no_ok", ok_cnt - ok0, 0);
    check("mid_idle", int'(Busy), 0);

    run_vec(8, vecs[0]);
    run_vec(9, vecs[7]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
